// File: rtl/dda_trace_plotter_pkg.sv
// Shared definitions for the DDA trace plotter.
// Holds the pixel codes used by the VGA colour decode, the plotter state
// encoding, the default screen geometry, bus widths and a column-wrap helper.
package dda_plot_pkg;

   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;

   localparam int COL_W    = 10;   // buffer column address width
   localparam int ROW_W    = 9;    // buffer row address width
   localparam int SAMPLE_W = 18;   // signed 2.16 displacement
   localparam int Y_W      = 11;   // signed row intermediate, wide enough to clamp
   localparam int DECIM_W  = 8;

   localparam logic [1:0] PIX_WHITE  = 2'b00;
   localparam logic [1:0] PIX_TRACE1 = 2'b01;
   localparam logic [1:0] PIX_TRACE2 = 2'b10;
   localparam logic [1:0] PIX_COINC  = 2'b11;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ERASE = 3'd2,
      ST_PLOT1 = 3'd3,
      ST_PLOT2 = 3'd4
   } plot_state_e;

   typedef struct packed {
      logic [COL_W-1:0] x;
      logic [ROW_W-1:0] y;
      logic [1:0]       data;
      logic             en;
   } pix_wr_t;

   // Next column with wrap from the last column back to 0.
   function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] c,
                                                 input int              w);
      return (c == COL_W'(w - 1)) ? '0 : c + 1'b1;
   endfunction

endpackage

// File: rtl/dda_trace_plotter_if.sv
// Sample and display-buffer bus of the DDA trace plotter.
//   sample_valid/sample_ready/x1/x2 : solver sample handshake
//   clear_req                       : single-cycle full-screen clear request
//   wr_x/wr_y/wr_data/wr_en         : display buffer port-a write
//   busy                            : plotter is not idle
// master = solver/driver side, slave = plotter side.
interface dda_trace_plotter_if;
   import dda_plot_pkg::*;

   logic                sample_valid;
   logic                sample_ready;
   logic [SAMPLE_W-1:0] x1;
   logic [SAMPLE_W-1:0] x2;
   logic                clear_req;
   logic [COL_W-1:0]    wr_x;
   logic [ROW_W-1:0]    wr_y;
   logic [1:0]          wr_data;
   logic                wr_en;
   logic                busy;

   modport master (
      output sample_valid, x1, x2, clear_req,
      input  sample_ready, wr_x, wr_y, wr_data, wr_en, busy
   );

   modport slave (
      input  sample_valid, x1, x2, clear_req,
      output sample_ready, wr_x, wr_y, wr_data, wr_en, busy
   );

endinterface

// File: rtl/dda_trace_plotter_y_map.sv
// Displacement-to-row mapping for one trace (purely combinational).
//   x_i : signed 2.16 displacement
//   y_o : screen row, CENTER - (x_i >>> Y_SHIFT), clamped to [0, SCREEN_H-1]
module dda_y_map
   import dda_plot_pkg::*;
#(
   parameter int CENTER   = 120,
   parameter int Y_SHIFT  = 10,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic signed [SAMPLE_W-1:0] x_i,
   output logic        [ROW_W-1:0]    y_o
);

   localparam logic signed [Y_W-1:0] CTR  = Y_W'(CENTER);
   localparam logic signed [Y_W-1:0] YMAX = Y_W'(SCREEN_H - 1);

   logic signed [Y_W-1:0] s;
   logic signed [Y_W-1:0] y;

   always_comb begin
      // Upward displacement moves the trace towards row 0.
      s = Y_W'(x_i >>> Y_SHIFT);
      y = CTR - s;
      if (y < 0) begin
         y_o = '0;
      end else if (y > YMAX) begin
         y_o = YMAX[ROW_W-1:0];
      end else begin
         y_o = y[ROW_W-1:0];
      end
   end

endmodule

// File: rtl/dda_trace_plotter.sv
// Strip-chart plotter for the DDA spring solver.
// Takes (x1, x2) samples over a valid/ready handshake and turns each plotted
// sample into display-buffer writes: erase the current column, plot trace 1
// (upper half) and trace 2 (lower half), then advance the column with wrap.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : sample handshake, clear request and buffer write port
//
// state | meaning
// CLEAR | write white to every pixel, x outer / y inner, then IDLE at column 0
// IDLE  | sample_ready high, waiting for a sample
// ERASE | write white down the current column, rows 0..SCREEN_H-1
// PLOT1 | write trace-1 pixel at (column, y1)
// PLOT2 | write trace-2 (or coincident) pixel at (column, y2), advance column
module dda_trace_plotter
   import dda_plot_pkg::*;
#(
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int SCREEN_H  = SCREEN_H_DEF,
   parameter int Y_SHIFT   = 10,
   parameter int Y1_CENTER = 120,
   parameter int Y2_CENTER = 360,
   parameter int DECIM     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   dda_trace_plotter_if.slave   bus
);

   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(SCREEN_W - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(SCREEN_H - 1);
   localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM - 1);

   plot_state_e        state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [DECIM_W-1:0] decim_q, decim_d;
   logic [ROW_W-1:0]   y1_q, y1_d;
   logic [ROW_W-1:0]   y2_q, y2_d;
   logic               fresh_q;
   pix_wr_t            wr_q, wr_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;

   logic [ROW_W-1:0]   y1_map;
   logic [ROW_W-1:0]   y2_map;
   logic               accept;

   dda_y_map #(
      .CENTER   (Y1_CENTER),
      .Y_SHIFT  (Y_SHIFT),
      .SCREEN_H (SCREEN_H)
   ) u_y1_map (
      .x_i (bus.x1),
      .y_o (y1_map)
   );

   dda_y_map #(
      .CENTER   (Y2_CENTER),
      .Y_SHIFT  (Y_SHIFT),
      .SCREEN_H (SCREEN_H)
   ) u_y2_map (
      .x_i (bus.x2),
      .y_o (y2_map)
   );

   assign accept = bus.sample_valid & ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         col_q   <= '0;
         row_q   <= '0;
         decim_q <= '0;
         y1_q    <= '0;
         y2_q    <= '0;
         fresh_q <= 1'b1;
         wr_q    <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         decim_q <= decim_d;
         y1_q    <= y1_d;
         y2_q    <= y2_d;
         fresh_q <= 1'b0;
         wr_q    <= wr_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      decim_d = decim_q;
      y1_d    = y1_q;
      y2_d    = y2_q;

      if (accept) begin
         y1_d = y1_map;
         y2_d = y2_map;
      end

      if (bus.clear_req && (state_q != ST_CLEAR)) begin
         state_d = ST_CLEAR;
         col_d   = '0;
         row_d   = '0;
         decim_d = '0;
      end else begin
         unique case (state_q)
            ST_CLEAR: begin
               // The first cycle out of reset issues pixel (0,0) without
               // advancing, since the write register is still zero then.
               if (!fresh_q) begin
                  if (row_q == ROW_LAST) begin
                     row_d = '0;
                     col_d = col_next(col_q, SCREEN_W);
                     if (col_q == COL_LAST) begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  if (decim_q == DECIM_LAST) begin
                     decim_d = '0;
                     row_d   = '0;
                     state_d = ST_ERASE;
                  end else begin
                     decim_d = decim_q + 1'b1;
                  end
               end
            end
            ST_ERASE: begin
               if (row_q == ROW_LAST) begin
                  state_d = ST_PLOT1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
            ST_PLOT1: begin
               state_d = ST_PLOT2;
            end
            ST_PLOT2: begin
               state_d = ST_IDLE;
               col_d   = col_next(col_q, SCREEN_W);
            end
            default: begin
               state_d = ST_CLEAR;
               col_d   = '0;
               row_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so the registered write lines
   // up with the state that owns it (no extra cycle of latency).
   always_comb begin
      wr_d    = '0;
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
      unique case (state_d)
         ST_CLEAR, ST_ERASE: begin
            wr_d.en   = 1'b1;
            wr_d.x    = col_d;
            wr_d.y    = row_d;
            wr_d.data = PIX_WHITE;
         end
         ST_PLOT1: begin
            wr_d.en   = 1'b1;
            wr_d.x    = col_d;
            wr_d.y    = y1_d;
            wr_d.data = PIX_TRACE1;
         end
         ST_PLOT2: begin
            wr_d.en   = 1'b1;
            wr_d.x    = col_d;
            wr_d.y    = y2_d;
            wr_d.data = (y2_d == y1_d) ? PIX_COINC : PIX_TRACE2;
         end
         default: begin
         end
      endcase
   end

   assign bus.sample_ready = ready_q;
   assign bus.busy         = busy_q;
   assign bus.wr_en        = wr_q.en;
   assign bus.wr_x         = wr_q.x;
   assign bus.wr_y         = wr_q.y;
   assign bus.wr_data      = wr_q.data;

endmodule
